fft_stream_host: RTL and testbench
==================================

Name: fft_stream_host

Overview:
- Upstream master for the FFT AXI-style bridge: sources time-domain samples into the bridge's read-data channel and sinks results from its write-data channel.
- Reads samples from a 1-cycle-latency source RAM and presents them with VALID/READY handshake.
- Accepts results and stores them in a destination RAM, with a start/busy/done control interface and a result-wait watchdog.
- Used as the system-level driver and as the reusable stimulus/collection block in FFT top-level benches.

Parameters:
- DATA_WIDTH, 32, width of sample/result words.
- IDX_WIDTH, 12, width of sample count and RAM addresses.
- TIMEOUT_CYCLES, 65535, max cycles in WAIT_RES before declaring timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_START  in  1  one-cycle request to run a frame; ignored unless IDLE
- i_SAMPLES_NUMBER  in  IDX_WIDTH  frame length N, latched on accepted start
- o_SRC_RE  out  1  source RAM read enable
- o_SRC_ADDR  out  IDX_WIDTH  source RAM address
- i_SRC_DATA  in  DATA_WIDTH  source RAM data, valid 1 cycle after o_SRC_RE
- o_ARVALID  out  1  sample valid toward bridge
- o_ARDATA  out  DATA_WIDTH  sample toward bridge
- i_ARREADY  in  1  bridge ready for sample
- o_ARBURST  out  2  constant INCR (2'b01)
- i_AWVALID  in  1  bridge result valid
- i_AWDATA  in  DATA_WIDTH  result word
- o_AWREADY  out  1  host ready for result
- o_AWBURST  out  2  constant INCR (2'b01)
- o_DST_WE  out  1  destination RAM write enable
- o_DST_ADDR  out  IDX_WIDTH  destination RAM address
- o_DST_DATA  out  DATA_WIDTH  destination RAM write data
- o_BUSY  out  1  high in every state except IDLE
- o_DONE  out  1  one-cycle pulse at frame completion
- o_TIMEOUT  out  1  one-cycle pulse when watchdog expires

Behaviour:
- Reset (i_rst high at a clock edge): state IDLE, index and watchdog counters 0, latched N = 0, o_ARDATA = 0. All control outputs 0: o_SRC_RE, o_ARVALID, o_AWREADY, o_DST_WE, o_BUSY, o_DONE, o_TIMEOUT. Address and data outputs 0.
- Reset mid-frame aborts the frame immediately, with no further RAM writes.
- Handshake: a transfer occurs on any cycle where VALID and READY are both high.
- VALID is held high, and its data is held stable, until the transfer occurs.
- The index counter has IDX_WIDTH bits, is shared by both phases, and is cleared on every phase change.
- IDLE:
  - On i_START with N != 0: latch N, clear index, go to FETCH.
  - On i_START with N == 0: go to DONE with no transfers.
- FETCH:
  - o_SRC_RE = 1, o_SRC_ADDR = index.
  - Next cycle register i_SRC_DATA into o_ARDATA and go to SEND.
- SEND:
  - o_ARVALID = 1.
  - On handshake with index == N-1: clear index, clear watchdog, go to WAIT_RES.
  - On handshake otherwise: index + 1, go to FETCH.
  - Throughput is one sample per 2 cycles minimum.
- WAIT_RES:
  - o_AWREADY = 1; the watchdog increments each cycle.
  - If i_AWVALID is high, the same cycle is a handshake. Write o_DST_WE = 1, o_DST_ADDR = index, o_DST_DATA = i_AWDATA. Then go to RECV (or DONE if N == 1), with index + 1.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without a handshake: pulse o_TIMEOUT and go to IDLE. No o_DONE is asserted.
- RECV:
  - o_AWREADY = 1.
  - Each handshake writes the destination RAM combinationally in the same cycle at address = index.
  - Handshake with index == N-1: go to DONE. Otherwise index + 1.
  - The watchdog is not active in RECV.
- DONE: o_DONE = 1 for one cycle, then IDLE. o_BUSY is still high in DONE.
- i_START outside IDLE is ignored. A change of i_SAMPLES_NUMBER mid-frame has no effect.
- i_AWVALID while in FETCH/SEND is not acknowledged (o_AWREADY = 0).
- o_ARBURST and o_AWBURST are constant 2'b01 in all states, including reset.
- Max frame length is 2^IDX_WIDTH - 1. Index never wraps within a frame.

Decomposition:
- Package fft_stream_host_fsm:
  - enum host_fsm {host_IDLE, host_FETCH, host_SEND, host_WAIT_RES, host_RECV, host_DONE}.
  - Constant BURST_INCR = 2'b01.
- One sub-module, fft_host_watchdog: clear/enable counter with parameter TIMEOUT_CYCLES and a one-cycle expire pulse.

Test Plan:
- Reset then N=4, source RAM {0x11,0x22,0x33,0x44}, i_ARREADY=1 always -> o_ARDATA sequence 0x11..0x44, exactly 4 AR handshakes, o_ARVALID low on alternate cycles.
- Same frame, then bridge returns {0xA0,0xA1,0xA2,0xA3} with i_AWVALID toggling 1/0 -> DST writes at addr 0..3 with those values in order, o_DONE pulses exactly once, o_BUSY drops the cycle after.
- i_ARREADY held low 5 cycles mid-frame -> o_ARVALID stays high with o_ARDATA stable, no index advance.
- N=0 start -> o_DONE pulse 1 cycle after start, no SRC/DST/AR/AW activity.
- TIMEOUT_CYCLES=8, no i_AWVALID after samples sent -> o_TIMEOUT pulses on cycle 8 of WAIT_RES, return to IDLE, no DST writes, no o_DONE.
- i_rst asserted during RECV at index 2 of N=4, second i_START during SEND -> all outputs reset values next cycle, no further writes; the extra start is ignored.

Source files
------------

// File: rtl/fft_stream_host_fsm.sv
// Shared state encoding and constants for the FFT stream host.
package fft_stream_host_fsm;

  typedef enum logic [2:0] {
    host_IDLE,
    host_FETCH,
    host_SEND,
    host_WAIT_RES,
    host_RECV,
    host_DONE
  } host_fsm;

  localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/fft_host_watchdog.sv
// Result-wait watchdog: counts enabled cycles and pulses expire on the last allowed cycle.
module fft_host_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The owner leaves the enabled state on expire, so the count never wraps.
  assign expire = en && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fft_stream_host.sv
// Upstream master for the FFT bridge: streams samples from a source RAM and stores results
// into a destination RAM under a start/busy/done interface with a result-wait watchdog.
module fft_stream_host
  import fft_stream_host_fsm::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned IDX_WIDTH      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_START,
  input  logic [IDX_WIDTH-1:0]  i_SAMPLES_NUMBER,
  output logic                  o_SRC_RE,
  output logic [IDX_WIDTH-1:0]  o_SRC_ADDR,
  input  logic [DATA_WIDTH-1:0] i_SRC_DATA,
  output logic                  o_ARVALID,
  output logic [DATA_WIDTH-1:0] o_ARDATA,
  input  logic                  i_ARREADY,
  output logic [1:0]            o_ARBURST,
  input  logic                  i_AWVALID,
  input  logic [DATA_WIDTH-1:0] i_AWDATA,
  output logic                  o_AWREADY,
  output logic [1:0]            o_AWBURST,
  output logic                  o_DST_WE,
  output logic [IDX_WIDTH-1:0]  o_DST_ADDR,
  output logic [DATA_WIDTH-1:0] o_DST_DATA,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_TIMEOUT
);

  host_fsm               state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [IDX_WIDTH-1:0]  n_q, n_d;
  logic [DATA_WIDTH-1:0] ardata_q;
  logic                  fresh_q;
  logic                  last_idx;
  logic                  dst_we;
  logic                  wd_clr;
  logic                  wd_en;
  logic                  wd_expire;

  assign last_idx = (idx_q == n_q - 1'b1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= host_IDLE;
      idx_q    <= '0;
      n_q      <= '0;
      ardata_q <= '0;
      fresh_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      fresh_q <= (state_q == host_FETCH);
      if (fresh_q) begin
        ardata_q <= i_SRC_DATA;
      end
    end
  end

  fft_host_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (i_clk),
    .rst   (i_rst),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    o_SRC_RE   = 1'b0;
    o_SRC_ADDR = '0;
    o_ARVALID  = 1'b0;
    o_AWREADY  = 1'b0;
    dst_we     = 1'b0;
    o_DST_ADDR = '0;
    o_DST_DATA = '0;
    o_DONE     = 1'b0;
    o_TIMEOUT  = 1'b0;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;

    unique case (state_q)
      host_IDLE: begin
        if (i_START) begin
          if (i_SAMPLES_NUMBER != '0) begin
            n_d     = i_SAMPLES_NUMBER;
            idx_d   = '0;
            state_d = host_FETCH;
          end else begin
            state_d = host_DONE;
          end
        end
      end
      host_FETCH: begin
        o_SRC_RE   = 1'b1;
        o_SRC_ADDR = idx_q;
        state_d    = host_SEND;
      end
      host_SEND: begin
        o_ARVALID = 1'b1;
        if (i_ARREADY) begin
          if (last_idx) begin
            idx_d   = '0;
            wd_clr  = 1'b1;
            state_d = host_WAIT_RES;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = host_FETCH;
          end
        end
      end
      host_WAIT_RES: begin
        o_AWREADY = 1'b1;
        wd_en     = 1'b1;
        if (i_AWVALID) begin
          dst_we     = 1'b1;
          o_DST_ADDR = idx_q;
          o_DST_DATA = i_AWDATA;
          if (last_idx) begin
            idx_d   = '0;
            state_d = host_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = host_RECV;
          end
        end else if (wd_expire) begin
          o_TIMEOUT = 1'b1;
          state_d   = host_IDLE;
        end
      end
      host_RECV: begin
        o_AWREADY = 1'b1;
        if (i_AWVALID) begin
          dst_we     = 1'b1;
          o_DST_ADDR = idx_q;
          o_DST_DATA = i_AWDATA;
          if (last_idx) begin
            idx_d   = '0;
            state_d = host_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      host_DONE: begin
        o_DONE  = 1'b1;
        state_d = host_IDLE;
      end
      default: state_d = host_IDLE;
    endcase
  end

  // The first SEND cycle forwards RAM data directly; later cycles replay the captured word.
  assign o_ARDATA  = fresh_q ? i_SRC_DATA : ardata_q;
  // A reset cycle must not commit a result that is being aborted.
  assign o_DST_WE  = dst_we & ~i_rst;
  assign o_BUSY    = (state_q != host_IDLE);
  assign o_ARBURST = BURST_INCR;
  assign o_AWBURST = BURST_INCR;

endmodule

// File: tb/tb_fft_stream_host.sv
// Directed bench for fft_stream_host with a synchronous source RAM and a scripted bridge.
module tb_fft_stream_host;

  localparam int DW = 32;
  localparam int IW = 12;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_START = 1'b0;
  logic [IW-1:0] i_SAMPLES_NUMBER = '0;
  logic          o_SRC_RE;
  logic [IW-1:0] o_SRC_ADDR;
  logic [DW-1:0] i_SRC_DATA = '0;
  logic          o_ARVALID;
  logic [DW-1:0] o_ARDATA;
  logic          i_ARREADY = 1'b0;
  logic [1:0]    o_ARBURST;
  logic          i_AWVALID = 1'b0;
  logic [DW-1:0] i_AWDATA = '0;
  logic          o_AWREADY;
  logic [1:0]    o_AWBURST;
  logic          o_DST_WE;
  logic [IW-1:0] o_DST_ADDR;
  logic [DW-1:0] o_DST_DATA;
  logic          o_BUSY;
  logic          o_DONE;
  logic          o_TIMEOUT;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src_mem [16];
  logic [DW-1:0] ar_log [16];
  int            ar_cyc [16];
  logic [IW-1:0] dst_addr_log [16];
  logic [DW-1:0] dst_data_log [16];
  int ar_n, dst_n, src_n, awr_n, done_n, to_n, cyc;

  always #5 clk = ~clk;

  fft_stream_host #(
    .DATA_WIDTH    (DW),
    .IDX_WIDTH     (IW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_START         (i_START),
    .i_SAMPLES_NUMBER(i_SAMPLES_NUMBER),
    .o_SRC_RE        (o_SRC_RE),
    .o_SRC_ADDR      (o_SRC_ADDR),
    .i_SRC_DATA      (i_SRC_DATA),
    .o_ARVALID       (o_ARVALID),
    .o_ARDATA        (o_ARDATA),
    .i_ARREADY       (i_ARREADY),
    .o_ARBURST       (o_ARBURST),
    .i_AWVALID       (i_AWVALID),
    .i_AWDATA        (i_AWDATA),
    .o_AWREADY       (o_AWREADY),
    .o_AWBURST       (o_AWBURST),
    .o_DST_WE        (o_DST_WE),
    .o_DST_ADDR      (o_DST_ADDR),
    .o_DST_DATA      (o_DST_DATA),
    .o_BUSY          (o_BUSY),
    .o_DONE          (o_DONE),
    .o_TIMEOUT       (o_TIMEOUT)
  );

  // Source RAM: data appears one cycle after the read enable.
  always @(posedge clk) begin
    if (o_SRC_RE) i_SRC_DATA <= src_mem[o_SRC_ADDR[3:0]];
  end

  always @(negedge clk) begin
    cyc++;
    if (o_ARVALID && i_ARREADY) begin
      if (ar_n < 16) begin
        ar_log[ar_n] = o_ARDATA;
        ar_cyc[ar_n] = cyc;
      end
      ar_n++;
    end
    if (o_DST_WE) begin
      if (dst_n < 16) begin
        dst_addr_log[dst_n] = o_DST_ADDR;
        dst_data_log[dst_n] = o_DST_DATA;
      end
      dst_n++;
    end
    if (o_SRC_RE) src_n++;
    if (o_AWREADY) awr_n++;
    if (o_DONE) done_n++;
    if (o_TIMEOUT) to_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ar_n = 0; dst_n = 0; src_n = 0; awr_n = 0; done_n = 0; to_n = 0;
  endtask

  task automatic pulse_start(input logic [IW-1:0] n);
    i_SAMPLES_NUMBER = n;
    i_START = 1'b1;
    tick();
    i_START = 1'b0;
  endtask

  task automatic wait_awready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (o_AWREADY) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Offers cnt results base, base+1, ...; toggle inserts an idle cycle after each offer.
  task automatic drive_results(input int cnt, input logic [DW-1:0] base, input bit toggle);
    int  k;
    bit  v;
    k = 0;
    v = 1'b1;
    for (int c = 0; c < 40 && k < cnt; c++) begin
      i_AWVALID = v;
      i_AWDATA  = base + DW'(k);
      if (v && o_AWREADY) k++;
      if (toggle) v = !v;
      tick();
    end
    i_AWVALID = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_SRC_RE, o_ARVALID, o_AWREADY, o_DST_WE, o_BUSY, o_DONE, o_TIMEOUT} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {o_SRC_RE, o_ARVALID, o_AWREADY, o_DST_WE, o_BUSY, o_DONE, o_TIMEOUT});
    end
    checks++;
    if ({o_SRC_ADDR, o_DST_ADDR, o_ARDATA, o_DST_DATA} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h want 0", o_SRC_ADDR, o_DST_ADDR, o_ARDATA,
               o_DST_DATA);
    end
    checks++;
    if ({o_ARBURST, o_AWBURST} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_burst got %b want 0101", {o_ARBURST, o_AWBURST});
    end
    i_rst = 1'b0;
    tick();
    checks++;
    if (o_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got %b want 0", o_BUSY);
    end
  endtask

  task automatic test_frame();
    logic [DW-1:0] exp_ar [4];
    bit ok;
    bit spacing_ok;
    exp_ar = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) src_mem[i] = exp_ar[i];
    clear_logs();
    i_ARREADY = 1'b1;
    pulse_start(12'd4);
    wait_awready(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_reach_wait got timeout want awready");
    end
    checks++;
    if (ar_n !== 4) begin
      errors++;
      $display("FAIL frame_ar_count got %0d want 4", ar_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ar_log[i] !== exp_ar[i]) begin
        errors++;
        $display("FAIL frame_ardata[%0d] got %h want %h", i, ar_log[i], exp_ar[i]);
      end
    end
    spacing_ok = 1'b1;
    for (int i = 1; i < 4; i++) if (ar_cyc[i] - ar_cyc[i-1] != 2) spacing_ok = 1'b0;
    checks++;
    if (!spacing_ok) begin
      errors++;
      $display("FAIL frame_ar_spacing got %0d,%0d,%0d want 2,2,2", ar_cyc[1] - ar_cyc[0],
               ar_cyc[2] - ar_cyc[1], ar_cyc[3] - ar_cyc[2]);
    end
    drive_results(4, 32'hA0, 1'b1);
    checks++;
    if ({o_DONE, o_BUSY} !== 2'b11) begin
      errors++;
      $display("FAIL frame_done_pulse got done=%b busy=%b want 1 1", o_DONE, o_BUSY);
    end
    tick();
    checks++;
    if ({o_DONE, o_BUSY} !== 2'b00) begin
      errors++;
      $display("FAIL frame_after_done got done=%b busy=%b want 0 0", o_DONE, o_BUSY);
    end
    checks++;
    if (dst_n !== 4 || done_n !== 1) begin
      errors++;
      $display("FAIL frame_dst_done_count got %0d/%0d want 4/1", dst_n, done_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dst_addr_log[i] !== IW'(i) || dst_data_log[i] !== 32'hA0 + DW'(i)) begin
        errors++;
        $display("FAIL frame_dst[%0d] got %0d:%h want %0d:%h", i, dst_addr_log[i],
                 dst_data_log[i], i, 32'hA0 + DW'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    src_mem[0] = 32'h55;
    src_mem[1] = 32'h66;
    src_mem[2] = 32'h77;
    clear_logs();
    i_ARREADY = 1'b1;
    pulse_start(12'd3);
    for (int c = 0; c < 20 && ar_n < 1; c++) tick();
    i_ARREADY = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({o_ARVALID, o_SRC_RE, o_ARDATA} !== {2'b10, 32'h66}) begin
        errors++;
        $display("FAIL stall[%0d] got valid=%b re=%b data=%h want 1 0 00000066", i, o_ARVALID,
                 o_SRC_RE, o_ARDATA);
      end
      tick();
    end
    i_ARREADY = 1'b1;
    wait_awready(ok);
    checks++;
    if (!ok || ar_n !== 3 || ar_log[1] !== 32'h66 || ar_log[2] !== 32'h77) begin
      errors++;
      $display("FAIL stall_resume got ok=%b n=%0d %h %h want 1 3 00000066 00000077", ok, ar_n,
               ar_log[1], ar_log[2]);
    end
    drive_results(3, 32'hB0, 1'b0);
    tick();
    checks++;
    if (dst_n !== 3 || dst_data_log[2] !== 32'hB2 || done_n !== 1) begin
      errors++;
      $display("FAIL stall_results got n=%0d last=%h done=%0d want 3 000000b2 1", dst_n,
               dst_data_log[2], done_n);
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    pulse_start(12'd0);
    checks++;
    if ({o_DONE, o_BUSY} !== 2'b11) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b want 1 1", o_DONE, o_BUSY);
    end
    tick();
    checks++;
    if ({o_DONE, o_BUSY} !== 2'b00) begin
      errors++;
      $display("FAIL zero_idle got done=%b busy=%b want 0 0", o_DONE, o_BUSY);
    end
    checks++;
    if (src_n !== 0 || ar_n !== 0 || dst_n !== 0 || awr_n !== 0 || done_n !== 1) begin
      errors++;
      $display("FAIL zero_activity got src=%0d ar=%0d dst=%0d aw=%0d done=%0d want 0 0 0 0 1",
               src_n, ar_n, dst_n, awr_n, done_n);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    i_ARREADY = 1'b1;
    i_AWVALID = 1'b0;
    pulse_start(12'd2);
    wait_awready(ok);
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (o_TIMEOUT !== (i == 8) || o_AWREADY !== 1'b1) begin
        errors++;
        $display("FAIL timeout_cycle[%0d] got to=%b awready=%b want %b 1", i, o_TIMEOUT,
                 o_AWREADY, i == 8);
      end
      tick();
    end
    checks++;
    if ({o_BUSY, o_AWREADY} !== 2'b00 || to_n !== 1 || done_n !== 0 || dst_n !== 0) begin
      errors++;
      $display("FAIL timeout_after got busy=%b aw=%b to=%0d done=%0d dst=%0d want 0 0 1 0 0",
               o_BUSY, o_AWREADY, to_n, done_n, dst_n);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    for (int i = 0; i < 4; i++) src_mem[i] = 32'h11 * DW'(i + 1);
    clear_logs();
    i_ARREADY = 1'b1;
    pulse_start(12'd4);
    tick();
    i_SAMPLES_NUMBER = 12'd2;
    i_START = 1'b1;
    tick();
    i_START = 1'b0;
    wait_awready(ok);
    checks++;
    if (!ok || ar_n !== 4) begin
      errors++;
      $display("FAIL extra_start_ignored got ok=%b ar=%0d want 1 4", ok, ar_n);
    end
    i_AWVALID = 1'b1;
    i_AWDATA = 32'hC0;
    tick();
    i_AWDATA = 32'hC1;
    tick();
    i_AWDATA = 32'hC2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_DST_WE !== 1'b0) begin
      errors++;
      $display("FAIL rst_cycle_write got %b want 0", o_DST_WE);
    end
    tick();
    i_rst = 1'b0;
    checks++;
    if ({o_SRC_RE, o_ARVALID, o_AWREADY, o_DST_WE, o_BUSY, o_DONE, o_TIMEOUT, o_SRC_ADDR,
         o_DST_ADDR, o_ARDATA, o_DST_DATA, o_ARBURST, o_AWBURST} !== {7'b0, 88'b0, 4'b0101}) begin
      errors++;
      $display("FAIL rst_mid_outputs got re=%b av=%b aw=%b we=%b busy=%b ard=%h want idle",
               o_SRC_RE, o_ARVALID, o_AWREADY, o_DST_WE, o_BUSY, o_ARDATA);
    end
    tick();
    tick();
    tick();
    i_AWVALID = 1'b0;
    checks++;
    if (dst_n !== 2 || done_n !== 0 || dst_data_log[1] !== 32'hC1 || o_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_writes got n=%0d done=%0d last=%h busy=%b want 2 0 000000c1 0",
               dst_n, done_n, dst_data_log[1], o_BUSY);
    end
  endtask

  initial begin
    cyc = 0;
    clear_logs();
    for (int i = 0; i < 16; i++) src_mem[i] = '0;
    test_reset();
    test_frame();
    test_backpressure();
    test_zero_len();
    test_timeout();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached at %0t want completion", $time);
    $fatal(1);
  end

endmodule
